// File: rtl/ann_layer_engine.sv
// Three-layer fully-connected inference engine on a shared MAC bank, with argmax classifier.
// Optional seven-segment result decoder is built when ANN_SEVEN_SEG_EN is defined.
module ann_layer_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int MAX_IN = 16,
  parameter int NODES  = 16,
  parameter int L1_N   = 16,
  parameter int L2_N   = 4,
  parameter int L3_N   = 10
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic [MAX_IN*DATA_W-1:0]    image_in,
  output logic                        coef_ready,
  input  logic                        coef_valid,
  input  logic [NODES*DATA_W-1:0]     coef_in,
  output logic [1:0]                  coef_layer,
  output logic [$clog2(MAX_IN)-1:0]   coef_index,
  output logic                        busy,
  output logic                        done,
  output logic [3:0]                  result_class,
  output logic [DATA_W-1:0]           result_value,
  output logic [7:0]                  seven_seg
);

  localparam int IDX_W = $clog2(MAX_IN);
  localparam int ACC_W = 2*DATA_W + IDX_W;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'd1 << (DATA_W-1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic [3:0] LAST_SCAN = 4'(L3_N-1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_ACT, S_ARGMAX, S_DONE} state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc      [NODES];
  logic signed [ACC_W-1:0]   acc_next [NODES];
  logic signed [DATA_W-1:0]  act_val  [NODES];
  logic signed [DATA_W-1:0]  pipe     [MAX_IN];
  logic [IDX_W-1:0]          last_idx;
  int unsigned               n_act;
  logic [3:0]                scan;
  logic signed [DATA_W-1:0]  best_val;
  logic [3:0]                best_cls;
  logic signed [DATA_W-1:0]  nxt_val;
  logic [3:0]                nxt_cls;
  logic                      scan_last;

  always_comb begin
    case (coef_layer)
      2'd2:    begin last_idx = IDX_W'(L1_N-1);   n_act = L2_N; end
      2'd3:    begin last_idx = IDX_W'(L2_N-1);   n_act = L3_N; end
      default: begin last_idx = IDX_W'(MAX_IN-1); n_act = L1_N; end
    endcase
  end

  // MAC update and activation share the per-node datapath; inactive nodes stay at zero.
  always_comb begin
    for (int unsigned n = 0; n < NODES; n++) begin
      logic signed [DATA_W-1:0]   w;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    sh;
      logic signed [DATA_W-1:0]   y;
      w    = signed'(coef_in[n*DATA_W +: DATA_W]);
      prod = w * pipe[coef_index];
      acc_next[n] = (n < n_act) ? acc[n] + ACC_W'(prod) : '0;
      sh = acc[n] >>> FRAC_W;
      if (sh > SAT_HI)      y = {1'b0, {(DATA_W-1){1'b1}}};
      else if (sh < SAT_LO) y = {1'b1, {(DATA_W-1){1'b0}}};
      else                  y = sh[DATA_W-1:0];
      if (coef_layer != 2'd3 && y[DATA_W-1]) y = '0;
      act_val[n] = (n < n_act) ? y : '0;
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    nxt_val = best_val;
    nxt_cls = best_cls;
    if (scan == 4'd0 || pipe[scan] > best_val) begin
      nxt_val = pipe[scan];
      nxt_cls = scan;
    end
    scan_last = (scan == LAST_SCAN);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      coef_ready   <= 1'b0;
      coef_layer   <= '0;
      coef_index   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_class <= '0;
      result_value <= '0;
      scan         <= '0;
      best_val     <= '0;
      best_cls     <= '0;
      for (int unsigned n = 0; n < NODES; n++) acc[n] <= '0;
      for (int unsigned i = 0; i < MAX_IN; i++) pipe[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int unsigned i = 0; i < MAX_IN; i++)
            pipe[i] <= signed'(image_in[i*DATA_W +: DATA_W]);
          for (int unsigned n = 0; n < NODES; n++) acc[n] <= '0;
          coef_layer <= 2'd1;
          coef_index <= '0;
          coef_ready <= 1'b1;
          state      <= S_FETCH;
        end
        S_FETCH: begin
          if (coef_valid) begin
            for (int unsigned n = 0; n < NODES; n++) acc[n] <= acc_next[n];
            if (coef_index == last_idx) begin
              coef_index <= '0;
              coef_ready <= 1'b0;
              state      <= S_ACT;
            end else begin
              coef_index <= coef_index + 1'b1;
            end
          end
        end
        S_ACT: begin
          for (int unsigned i = 0; i < MAX_IN; i++) begin
            if (i < NODES) pipe[i] <= act_val[i];
            else           pipe[i] <= '0;
          end
          for (int unsigned n = 0; n < NODES; n++) acc[n] <= '0;
          coef_index <= '0;
          if (coef_layer == 2'd3) begin
            coef_layer <= '0;
            scan       <= '0;
            state      <= S_ARGMAX;
          end else begin
            coef_layer <= coef_layer + 2'd1;
            coef_ready <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_ARGMAX: begin
          best_val <= nxt_val;
          best_cls <= nxt_cls;
          if (scan_last) begin
            result_class <= nxt_cls;
            result_value <= nxt_val;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= S_DONE;
          end else begin
            scan <= scan + 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ANN_SEVEN_SEG_EN
  logic [7:0] seg_q;

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 8'hC0;
      4'h1: seg_decode = 8'hF9;
      4'h2: seg_decode = 8'hA4;
      4'h3: seg_decode = 8'hB0;
      4'h4: seg_decode = 8'h99;
      4'h5: seg_decode = 8'h92;
      4'h6: seg_decode = 8'h82;
      4'h7: seg_decode = 8'hF8;
      4'h8: seg_decode = 8'h80;
      4'h9: seg_decode = 8'h90;
      4'hA: seg_decode = 8'h88;
      4'hB: seg_decode = 8'h83;
      4'hC: seg_decode = 8'hC6;
      4'hD: seg_decode = 8'hA1;
      4'hE: seg_decode = 8'h86;
      default: seg_decode = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!n_rst)                               seg_q <= 8'hFF;
    else if (state == S_ARGMAX && scan_last)  seg_q <= seg_decode(nxt_cls);
  end

  assign seven_seg = seg_q;
`else
  assign seven_seg = 8'hFF;
`endif

endmodule

// File: tb/tb_ann_layer_engine.sv
// Directed bench for ann_layer_engine: classify, saturation/ReLU, backpressure, tie, abort.
module tb_ann_layer_engine;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [255:0] image_in;
  logic         coef_ready;
  logic         coef_valid;
  logic [255:0] coef_in;
  logic [1:0]   coef_layer;
  logic [3:0]   coef_index;
  logic         busy;
  logic         done;
  logic [3:0]   result_class;
  logic [15:0]  result_value;
  logic [7:0]   seven_seg;

  int total = 0;
  int bad   = 0;
  int mode  = 0;

  always #5 clk = ~clk;

  ann_layer_engine dut (
    .clk(clk), .n_rst(n_rst), .start(start), .image_in(image_in),
    .coef_ready(coef_ready), .coef_valid(coef_valid), .coef_in(coef_in),
    .coef_layer(coef_layer), .coef_index(coef_index), .busy(busy), .done(done),
    .result_class(result_class), .result_value(result_value), .seven_seg(seven_seg)
  );

  // Coefficient memory: one column per (layer, index) for each test scenario.
  function automatic logic [255:0] col(input int m, input logic [1:0] l, input logic [3:0] i);
    logic [15:0] w;
    col = '0;
    for (int n = 0; n < 16; n++) begin
      w = 16'h0000;
      case (l)
        2'd1: w = (m == 1) ? 16'h7FFF : (m == 2) ? 16'h8000 : 16'h0100;
        2'd2: w = (m == 1) ? ((n == 0) ? 16'h0010 : 16'h0000) : (m == 2) ? 16'hFFF0 : 16'h0010;
        2'd3: begin
          case (m)
            0: w = (n == 7) ? 16'h0100 : 16'h0000;
            1, 2: w = (n == 3) ? 16'h0100 : 16'h0000;
            3: w = 16'hFFFC;
            default: w = (i == 4'd0) ? ((n == 2 || n == 6) ? 16'h0030 : 16'h0010) : 16'h0000;
          endcase
        end
        default: w = 16'h0000;
      endcase
      col[n*16 +: 16] = w;
    end
  endfunction

  assign coef_in = col(mode, coef_layer, coef_index);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input int m, input logic [3:0] ecls,
                     input logic [15:0] eval, input int elat, input logic [7:0] eseg,
                     input bit stall, input bit ign);
    int lat;
    int stalls;
    bit st;
    mode     = m;
    image_in = (m == 1) ? {16{16'h7FFF}} : {16{16'h0100}};
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat    = 0;
    stalls = 0;
    while (lat < 200) begin
      @(negedge clk);
      start      = ign && (lat == 5);
      coef_valid = 1'b1;
      st         = 1'b0;
      if (stall && coef_layer == 2'd2 && coef_index == 4'd5 && stalls < 3) begin
        coef_valid = 1'b0;
        stalls++;
        st = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
      if (st) check({tag, "_hold_idx"}, coef_index, 5);
      if (done) break;
    end
    start      = 1'b0;
    coef_valid = 1'b1;
    check({tag, "_latency"}, lat, elat);
    check({tag, "_done"}, done, 1);
    check({tag, "_class"}, result_class, ecls);
    check({tag, "_value"}, result_value, eval);
    check({tag, "_busy"}, busy, 0);
`ifdef ANN_SEVEN_SEG_EN
    check({tag, "_seg"}, seven_seg, eseg);
`else
    check({tag, "_seg"}, seven_seg, 8'hFF);
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold_class"}, result_class, ecls);
  endtask

  initial begin
    int cnt;
    int dones;
    n_rst      = 1'b0;
    start      = 1'b0;
    coef_valid = 1'b1;
    image_in   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("reset_outputs",
          {coef_ready, busy, done, coef_layer, coef_index, result_class, result_value, seven_seg},
          64'h0FF);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_outputs",
            {coef_ready, busy, done, coef_layer, coef_index, result_class, result_value, seven_seg},
            64'h0FF);
    end

    run("classify", 0, 4'd7, 16'h4000, 50, 8'hF8, 1'b0, 1'b0);
    run("saturate", 1, 4'd3, 16'h7FFF, 50, 8'hB0, 1'b0, 1'b0);
    run("relu",     2, 4'd0, 16'h0000, 50, 8'hC0, 1'b0, 1'b0);
    run("neg_l3",   3, 4'd0, 16'hFF00, 50, 8'hC0, 1'b0, 1'b0);
    run("backpres", 0, 4'd7, 16'h4000, 53, 8'hF8, 1'b1, 1'b0);
    run("tie",      4, 4'd2, 16'h0300, 50, 8'hA4, 1'b0, 1'b0);
    run("ign_start",0, 4'd7, 16'h4000, 50, 8'hF8, 1'b0, 1'b1);

    mode     = 0;
    image_in = {16{16'h0100}};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (coef_layer != 2'd2 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("abort_reach_l2", coef_layer, 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", coef_ready, 0);
    check("abort_layer", coef_layer, 0);
    check("abort_result", {result_class, result_value}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    dones = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    run("fresh", 0, 4'd7, 16'h4000, 50, 8'hF8, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
